// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage constants, packet type and PC alignment helper
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~XLEN'(INSTR_BYTES - 1);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with async reset, flush, occupancy count and full/empty
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  // a push into a full FIFO is accepted only when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push & ~flush) mem[wp] <= din;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, credit-limited imem requests, {pc,instr} buffer and redirect flushing
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            id_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] pc, pcq_head;
  logic [CW-1:0] inflight, drop, buf_count;
  logic issue, rv, keep, pop, buf_empty, buf_full, pcq_empty, pcq_full;
  fetch_pkt_t head;
  assign issue = imem_req & imem_gnt;
  assign rv = imem_rvalid & (inflight != '0);
  // responses still owed to a pre-redirect path are discarded until drop drains
  assign keep = rv & (drop == '0) & ~pcq_empty;
  assign pop = ~buf_empty & id_ready;
  assign imem_req = ~rst & (({1'b0, inflight} + {1'b0, buf_count}) < (CW+1)'(DEPTH)) & ~pcq_full & ~buf_full;
  assign imem_addr = pc;
  assign if_valid = ~buf_empty;
  assign if_pc = buf_empty ? '0 : head.pc;
  assign if_instr = buf_empty ? '0 : head.instr;
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) pcq (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(issue), .din(pc), .pop(keep),
    .dout(pcq_head), .count(), .full(pcq_full), .empty(pcq_empty)
  );
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_pkt_t))) obuf (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(keep), .din(fetch_pkt_t'{pc: pcq_head, instr: imem_rdata}), .pop(pop),
    .dout(head), .count(buf_count), .full(buf_full), .empty(buf_empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      inflight <= '0;
      drop <= '0;
    end else begin
      pc <= redirect_valid ? align_pc(redirect_pc) : issue ? pc + XLEN'(INSTR_BYTES) : pc;
      inflight <= inflight + CW'(issue) - CW'(rv);
      drop <= redirect_valid ? inflight + CW'(issue) - CW'(rv) : drop - CW'(rv && drop != '0);
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table, corner sequences and randomized run against a queue-based model
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0, redirect_valid = 0, if_valid, id_ready = 0;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, if_pc, if_instr;
  always #5 clk = ~clk;
  instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready)
  );
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [31:0] pc; bit drop;} fl_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} be_t;
  typedef struct {bit rdy; bit req; logic [31:0] addr; bit valid; logic [31:0] pc;} vec_t;
  fl_t m_fl[$];
  be_t m_buf[$];
  logic [31:0] m_pc;
  logic [31:0] r_q[$];
  bit stray = 0;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc;
  vec_t tbl[11];
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m_fl.delete();
    m_buf.delete();
    r_q.delete();
    m_pc = 32'h0;
  endtask
  task automatic do_reset();
    imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; id_ready = 0;
    rst = 1;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask
  // one clock: drive inputs, compare against the model, then advance model and memory responder
  task automatic tick(input bit g, input bit want_rv, input bit rdir, input logic [31:0] rpc, input bit rdy);
    bit rv, m_req, m_issue, d_issue;
    logic [31:0] d_addr;
    fl_t f;
    be_t b;
    rv = want_rv && (r_q.size() > 0 || stray);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = r_q.size() > 0 ? memf(r_q[0]) : $urandom;
    redirect_valid = rdir; redirect_pc = rpc; id_ready = rdy;
    #1;
    m_req = (m_fl.size() + m_buf.size()) < DEPTH;
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid; s_pc = if_pc;
    chk("imem_req", 32'(imem_req), 32'(m_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_buf.size() > 0));
    chk("if_pc", if_pc, m_buf.size() > 0 ? m_buf[0].pc : 32'h0);
    chk("if_instr", if_instr, m_buf.size() > 0 ? m_buf[0].instr : 32'h0);
    d_issue = imem_req && g;
    d_addr = imem_addr;
    m_issue = m_req && g;
    if (rdy && m_buf.size() > 0) void'(m_buf.pop_front());
    if (rv && m_fl.size() > 0) begin
      f = m_fl.pop_front();
      if (!f.drop) begin
        b.pc = f.pc;
        b.instr = memf(f.pc);
        m_buf.push_back(b);
      end
    end
    if (m_issue) begin
      f.pc = m_pc;
      f.drop = 0;
      m_fl.push_back(f);
      m_pc += 32'd4;
    end
    if (rdir) begin
      foreach (m_fl[i]) m_fl[i].drop = 1;
      m_buf.delete();
      m_pc = rpc & ~32'h3;
    end
    if (rv && r_q.size() > 0) void'(r_q.pop_front());
    if (d_issue) r_q.push_back(d_addr);
    @(posedge clk);
    #1;
  endtask
  task automatic expect_first(input string nm, input logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1, 1, 0, 32'h0, 1);
      if (s_valid) begin
        found = 1;
        chk(nm, s_pc, pc);
      end
    end
    chk({nm, "_seen"}, 32'(found), 32'h1);
  endtask
  initial begin
    tbl[0]  = '{1, 1, 32'h00, 0, 32'h0};
    tbl[1]  = '{1, 1, 32'h04, 0, 32'h0};
    tbl[2]  = '{1, 0, 32'h08, 1, 32'h0};
    tbl[3]  = '{1, 1, 32'h08, 1, 32'h4};
    tbl[4]  = '{0, 1, 32'h0C, 0, 32'h0};
    tbl[5]  = '{0, 0, 32'h10, 1, 32'h8};
    tbl[6]  = '{0, 0, 32'h10, 1, 32'h8};
    tbl[7]  = '{0, 0, 32'h10, 1, 32'h8};
    tbl[8]  = '{0, 0, 32'h10, 1, 32'h8};
    tbl[9]  = '{1, 0, 32'h10, 1, 32'h8};
    tbl[10] = '{1, 1, 32'h10, 1, 32'hC};
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 32'h0, 0);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      tick(1, 1, 0, 32'h0, tbl[i].rdy);
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
    end
    do_reset();
    tick(1, 0, 0, 32'h0, 1);
    tick(1, 0, 0, 32'h0, 1);
    tick(0, 0, 1, 32'h100, 1);
    chk("redir_req_held", 32'(s_req), 32'h0);
    expect_first("redir_first_pc", 32'h100);
    do_reset();
    tick(0, 0, 1, 32'hFFFF_FFFE, 1);
    tick(1, 0, 0, 32'h0, 1);
    chk("wrap_addr_hi", s_addr, 32'hFFFF_FFFC);
    chk("wrap_req", 32'(s_req), 32'h1);
    tick(1, 0, 0, 32'h0, 1);
    chk("wrap_addr_lo", s_addr, 32'h0);
    expect_first("wrap_first_pc", 32'hFFFF_FFFC);
    do_reset();
    tick(1, 0, 0, 32'h0, 1);
    tick(1, 1, 1, 32'h200, 1);
    expect_first("simul_first_pc", 32'h200);
    stray = 1;
    for (int i = 0; i < 3000; i++)
      tick(bit'($urandom_range(0, 1)), $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
           $urandom, $urandom_range(0, 99) < 70);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
